// File: rtl/ch_dot_reduce_pkg.sv
// Shared constants, accumulator FSM encoding and the fp16 arithmetic used by
// every multiplier/adder wrapper of the C.h row reduction.
package ch_dot_reduce_pkg;

  localparam int N_TILE_DEF     = 16;
  localparam int MUL_LAT_DEF    = 6;
  localparam int ADD_LAT_DEF    = 11;
  localparam int FIFO_DEPTH_DEF = 8;

  localparam int LOG2N    = $clog2(N_TILE_DEF);
  localparam int PIPE_LAT = MUL_LAT_DEF + LOG2N * ADD_LAT_DEF;
  localparam int FIFO_PW  = $clog2(FIFO_DEPTH_DEF);

  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2
  } acc_state_e;

  // Round-to-nearest-even of an 11-bit significand (hidden one at bit 10).
  // Subnormal results flush to signed zero, overflow saturates to infinity.
  function automatic logic [15:0] fp16_pack(input logic sign, input int exp_v,
                                            input logic [10:0] sig, input logic guard,
                                            input logic sticky);
    logic [11:0] rnd;
    int          e;
    e   = exp_v;
    rnd = {1'b0, sig};
    if (guard && (sticky || sig[0])) rnd = rnd + 12'd1;
    if (rnd[11]) begin
      e   = e + 1;
      rnd = rnd >> 1;
    end
    if (e >= 31) return {sign, 5'h1f, 10'h000};
    if (e <= 0) return {sign, 15'h0000};
    return {sign, e[4:0], rnd[9:0]};
  endfunction

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        sign;
    logic [21:0] prod;
    int          e;
    sign = a[15] ^ b[15];
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {sign, 5'h1f, 10'h000};
    if (a[14:10] == 5'h00 || b[14:10] == 5'h00) return {sign, 15'h0000};
    prod = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e    = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (prod[21]) return fp16_pack(sign, e + 1, prod[21:11], prod[10], |prod[9:0]);
    return fp16_pack(sign, e, prod[20:10], prod[9], |prod[8:0]);
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    logic [15:0] y;
    logic [14:0] mx;
    logic [14:0] my;
    logic [14:0] sum;
    logic        sticky;
    int          d;
    int          e;
    if (a[14:10] == 5'h00) return (b[14:10] == 5'h00) ? {a[15] & b[15], 15'h0000} : b;
    if (b[14:10] == 5'h00) return a;
    if (a[14:10] == 5'h1f) return a;
    if (b[14:10] == 5'h1f) return b;
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    // Three extra low bits hold guard/round/sticky of the aligned operand.
    d  = int'(x[14:10]) - int'(y[14:10]);
    mx = {2'b01, x[9:0], 3'b000};
    my = {2'b01, y[9:0], 3'b000};
    if (d > 13) begin
      my = 15'd1;
    end else begin
      sticky = 1'b0;
      for (int i = 0; i < 14; i++) if (i < d) sticky = sticky | my[i];
      my = (my >> d) | {14'd0, sticky};
    end
    sum = (x[15] == y[15]) ? mx + my : mx - my;
    if (sum == 15'd0) return FP16_ZERO;
    e = int'(x[14:10]);
    if (sum[14]) begin
      sum = {1'b0, sum[14:1]} | {14'd0, sum[0]};
      e   = e + 1;
    end else begin
      for (int i = 0; i < 13; i++) begin
        if (!sum[13]) begin
          sum = sum << 1;
          e   = e - 1;
        end
      end
    end
    return fp16_pack(x[15], e, sum[13:3], sum[2], |sum[1:0]);
  endfunction

endpackage

// File: rtl/ch_dot_reduce_add_tree.sv
// Balanced pairwise fp16 adder tree, N inputs to one output, LOG2(N)*ADD_LAT latency.
module fp16_add_tree #(
  parameter int N       = 16,
  parameter int ADD_LAT = 11
) (
  input  logic            clk,
  input  logic [N*16-1:0] x_i,
  output logic [15:0]     y_o
);

  // Heap layout: leaves at N..2N-1, node k sums children 2k and 2k+1, root is 1.
  logic [15:0] node [1:2*N-1];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_leaf
      assign node[N+gi] = x_i[gi*16 +: 16];
    end
    for (gi = 1; gi < N; gi++) begin : g_node
      fp16_add_wrapper #(.LAT(ADD_LAT)) u_add (
        .clk(clk),
        .a_i(node[2*gi]),
        .b_i(node[2*gi+1]),
        .s_o(node[gi])
      );
    end
  endgenerate

  assign y_o = node[1];

endmodule

// File: rtl/ch_dot_reduce_fp16.sv
// Fixed-latency fp16 multiply and add wrappers: combinational op followed by a
// LAT-deep register chain with no reset (output valid LAT cycles after input).
module fp16_mult_wrapper
  import ch_dot_reduce_pkg::*;
#(
  parameter int LAT = 6
) (
  input  logic        clk,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] p_o
);

  logic [15:0] pipe_q [LAT];

  always_ff @(posedge clk) begin
    pipe_q[0] <= fp16_mul(a_i, b_i);
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign p_o = pipe_q[LAT-1];

endmodule

module fp16_add_wrapper
  import ch_dot_reduce_pkg::*;
#(
  parameter int LAT = 11
) (
  input  logic        clk,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] s_o
);

  logic [15:0] pipe_q [LAT];

  always_ff @(posedge clk) begin
    pipe_q[0] <= fp16_add(a_i, b_i);
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign s_o = pipe_q[LAT-1];

endmodule

// File: rtl/ch_dot_reduce.sv
// Row dot-product reduction y = sum_n C[n]*h[n] over the N tiles of a row, with
// credit-guarded partial-sum FIFO and a single-adder row accumulator.
module ch_dot_reduce
  import ch_dot_reduce_pkg::*;
#(
  parameter int DW         = 16,
  parameter int N_TILE     = N_TILE_DEF,
  parameter int MUL_LAT    = MUL_LAT_DEF,
  parameter int ADD_LAT    = ADD_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 last_i,
  input  logic [N_TILE*DW-1:0] h_i,
  input  logic [N_TILE*DW-1:0] C_i,
  output logic [DW-1:0]        y_o,
  output logic                 valid_o
);

  localparam int TREE_LVLS  = $clog2(N_TILE);
  localparam int PIPE_DEPTH = MUL_LAT + TREE_LVLS * ADD_LAT;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int WCNT_W     = $clog2(ADD_LAT + 1);

  logic                 accept;
  logic [N_TILE*DW-1:0] prod;
  logic [DW-1:0]        partial;

  assign accept = valid_i & ready_o;

  genvar gi;
  generate
    for (gi = 0; gi < N_TILE; gi++) begin : g_mul
      fp16_mult_wrapper #(.LAT(MUL_LAT)) u_mul (
        .clk(clk),
        .a_i(h_i[gi*DW +: DW]),
        .b_i(C_i[gi*DW +: DW]),
        .p_o(prod[gi*DW +: DW])
      );
    end
  endgenerate

  fp16_add_tree #(.N(N_TILE), .ADD_LAT(ADD_LAT)) u_tree (
    .clk(clk),
    .x_i(prod),
    .y_o(partial)
  );

  // Validity is tracked here rather than in the wrappers so a reset drops
  // everything in flight even though the datapath itself is never cleared.
  logic [PIPE_DEPTH-1:0] vld_sr_q;
  logic [PIPE_DEPTH-1:0] last_sr_q;
  logic                  fifo_wr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_sr_q  <= '0;
      last_sr_q <= '0;
    end else begin
      vld_sr_q  <= {vld_sr_q[PIPE_DEPTH-2:0], accept};
      last_sr_q <= {last_sr_q[PIPE_DEPTH-2:0], accept & last_i};
    end
  end

  assign fifo_wr = vld_sr_q[PIPE_DEPTH-1];

  logic [DW:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic [CNT_W-1:0] inflight_q;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [DW:0]      head;

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem_q[wr_ptr_q] <= {last_sr_q[PIPE_DEPTH-1], partial};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      inflight_q <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({fifo_wr, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      case ({accept, fifo_wr})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Every accepted beat owns a FIFO slot from acceptance on, so the FIFO never overflows.
  assign ready_o    = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < (CNT_W+1)'(FIFO_DEPTH);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];

  acc_state_e        state_q;
  acc_state_e        state_d;
  logic [DW-1:0]     acc_q;
  logic [DW-1:0]     y_q;
  logic [DW-1:0]     sum;
  logic              valid_q;
  logic              first_q;
  logic              pend_last_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              load_part;
  logic              load_sum;
  logic              start_add;
  logic              emit;

  fp16_add_wrapper #(.LAT(ADD_LAT)) u_acc_add (
    .clk(clk),
    .a_i(acc_q),
    .b_i(head[DW-1:0]),
    .s_o(sum)
  );

  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    load_part = 1'b0;
    load_sum  = 1'b0;
    start_add = 1'b0;
    emit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (first_q) begin
            load_part = 1'b1;
            if (head[DW]) state_d = ST_EMIT;
          end else begin
            start_add = 1'b1;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == WCNT_W'(ADD_LAT)) begin
          load_sum = 1'b1;
          state_d  = pend_last_q ? ST_EMIT : ST_IDLE;
        end
      end
      ST_EMIT: begin
        emit    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      acc_q       <= FP16_ZERO;
      y_q         <= FP16_ZERO;
      valid_q     <= 1'b0;
      first_q     <= 1'b1;
      pend_last_q <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= emit;
      if (load_part) acc_q <= head[DW-1:0];
      else if (load_sum) acc_q <= sum;
      // The adder sees acc/head in the pop cycle; its result lands ADD_LAT cycles later.
      if (start_add) begin
        pend_last_q <= head[DW];
        wcnt_q      <= WCNT_W'(1);
      end else if (state_q == ST_WAIT) begin
        wcnt_q <= wcnt_q + WCNT_W'(1);
      end
      if (emit) begin
        y_q     <= acc_q;
        first_q <= 1'b1;
      end else if (fifo_pop && !head[DW]) begin
        first_q <= 1'b0;
      end
    end
  end

  assign y_o     = y_q;
  assign valid_o = valid_q;

endmodule
